lfsr_seq_ctrl: RTL

- Sequencing controller for the maximal-length LFSR PRBS generator.
- Seeds the LFSR, gates its stepping on the sample-rate enable and counts samples.
- Pulses `cycle` at every full period, checks that the LFSR returns to its seed after exactly 2^WIDTH-1 steps, and checks for lock-up.
- Sits between the clk_en timing block and the LFSR; a testbench or top-level host issues start/stop.

---
 rtl/lfsr_seq_ctrl.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lfsr_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_ctrl
// Description : Sequencing controller for a maximal-length LFSR PRBS source.
//               Seeds the LFSR, gates its stepping on the sample-rate strobe,
//               counts samples and pulses `cycle` once per full period.
//               Optional macro LFSR_SEQ_CHECK_EN enables the period
//               (short/long) and lock-up checks that drive pass/fail; without
//               it pass/fail are tied low and lfsr_state is not inspected.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_ctrl #(
    parameter int               WIDTH     = 22,
    parameter logic [WIDTH-1:0] SEED      = {WIDTH{1'b1}},
    parameter int               N_PERIODS = 1,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sam_clk_en,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] lfsr_state,
    output logic             load,
    output logic             step_en,
    output logic             cycle,
    output logic             busy,
    output logic             pass,
    output logic             fail,
    output logic [CNT_W-1:0] cycle_cnt
);

    // Last sample index of a period (2^WIDTH-2); the strobe seen here wraps.
    localparam logic [WIDTH-1:0] CNT_LAST    = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] N_PER       = CNT_W'(N_PERIODS);
    localparam bit               RUN_FOREVER = (N_PERIODS == 0);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sample_cnt;
    logic [WIDTH-1:0] sample_cnt_nxt;
    logic [CNT_W-1:0] cycle_cnt_q;
    logic [CNT_W-1:0] cycle_cnt_nxt;
    logic [CNT_W-1:0] cycle_cnt_inc;

    // Event flags handed from the FSM to the pass/fail bookkeeping.
    logic run_clear;   // fresh run accepted: clear verdicts
    logic period_ok;   // period verified in CHECK
    logic err_hit;     // a check failed this clk

    // Datapath observations of the LFSR register.
    logic seed_match;
    logic lock_up;
    logic short_period;

`ifdef LFSR_SEQ_CHECK_EN
    assign seed_match   = (lfsr_state == SEED);
    assign lock_up      = (lfsr_state == '0);
    // Returning to the seed mid-period means the sequence is too short.
    assign short_period = (sample_cnt != '0) && seed_match;
`else
    assign seed_match   = 1'b1;
    assign lock_up      = 1'b0;
    assign short_period = 1'b0;
`endif

    // Saturating increment of the completed-period count.
    assign cycle_cnt_inc = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q
                                                    : cycle_cnt_q + CNT_W'(1);

    // State, sample counter and period counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            sample_cnt  <= '0;
            cycle_cnt_q <= '0;
        end else begin
            state       <= state_nxt;
            sample_cnt  <= sample_cnt_nxt;
            cycle_cnt_q <= cycle_cnt_nxt;
        end
    end

    // Next-state, counter updates and Moore/Mealy outputs.
    always_comb begin
        state_nxt      = state;
        sample_cnt_nxt = sample_cnt;
        cycle_cnt_nxt  = cycle_cnt_q;
        load           = 1'b0;
        step_en        = 1'b0;
        cycle          = 1'b0;
        busy           = 1'b0;
        run_clear      = 1'b0;
        period_ok      = 1'b0;
        err_hit        = 1'b0;

        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_nxt      = S_LOAD;
                    run_clear      = 1'b1;
                    sample_cnt_nxt = '0;
                    cycle_cnt_nxt  = '0;
                end
            end

            // Hold load until the LFSR actually takes the seed on a strobe.
            S_LOAD: begin
                load = 1'b1;
                busy = 1'b1;
                if (sam_clk_en) begin
                    state_nxt = S_RUN;
                end
            end

            S_RUN: begin
                step_en = 1'b1;
                busy    = 1'b1;
                if (lock_up) begin
                    err_hit = 1'b1;
                end else if (sam_clk_en) begin
                    if (sample_cnt == CNT_LAST) begin
                        sample_cnt_nxt = '0;
                        state_nxt      = S_CHECK;
                    end else begin
                        sample_cnt_nxt = sample_cnt + WIDTH'(1);
                    end
                end else if (short_period) begin
                    err_hit = 1'b1;
                end
            end

            // LFSR has just made its last step of the period: must be SEED.
            S_CHECK: begin
                busy = 1'b1;
                if (lock_up || !seed_match) begin
                    err_hit = 1'b1;
                end else begin
                    cycle         = 1'b1;
                    period_ok     = 1'b1;
                    cycle_cnt_nxt = cycle_cnt_inc;
                    if (!RUN_FOREVER && (cycle_cnt_inc == N_PER)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_RUN;
                    end
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (err_hit) begin
            state_nxt = S_ERR;
        end

        // Stop wins over everything: abort and freeze counters/verdicts.
        if (stop) begin
            state_nxt      = S_IDLE;
            sample_cnt_nxt = sample_cnt;
            cycle_cnt_nxt  = cycle_cnt_q;
            cycle          = 1'b0;
            run_clear      = 1'b0;
            period_ok      = 1'b0;
            err_hit        = 1'b0;
        end
    end

    assign cycle_cnt = cycle_cnt_q;

`ifdef LFSR_SEQ_CHECK_EN
    logic pass_q;
    logic fail_q;

    // Sticky verdicts; cleared only when a fresh run starts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (run_clear) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (err_hit) begin
            pass_q <= 1'b0;
            fail_q <= 1'b1;
        end else if (period_ok) begin
            pass_q <= 1'b1;
        end
    end

    assign pass = pass_q;
    assign fail = fail_q;
`else
    // Checks compiled out: verdicts tied low, LFSR contents not inspected.
    logic unused_chk;
    assign unused_chk = ^{lfsr_state, run_clear, period_ok, err_hit};
    assign pass = 1'b0;
    assign fail = 1'b0;
`endif

endmodule
`default_nettype wire
